traffic_generator_stream: RTL and testbench

Parametrised successor of the single-lane GMII frame generator. Transmits a template frame from an external frame buffer as a byte-lane stream of LANES bytes per beat. Adds burst shaping (frames per burst, inter-burst gap) and optional in-frame insertion of sequence number and timestamp. It sits between the register/frame-buffer block and the MAC/PHY-side transmit interface (GMII at LANES=1, wider internal streams otherwise).

---
 rtl/traffic_generator_pkg.sv | 17 +
 rtl/traffic_generator_stream_if.sv | 14 +
 rtl/tg_stamp_mux.sv | 32 +++
 rtl/traffic_generator_stream.sv | 143 ++++++++++++++
 tb/tb_traffic_generator_stream.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_generator_pkg.sv
// Shared types and stamp layout for the stream traffic generator.
package traffic_generator_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FRAME, GAP} tg_state_t;

  localparam int unsigned STAMP_LEN = 14;

  // Stamp byte idx of {seq, sec, 2'b00, nsec}, big-endian, idx 0 first on the wire.
  function automatic logic [7:0] stamp_byte(input int unsigned idx, input logic [31:0] seq,
                                            input logic [47:0] sec, input logic [29:0] nsec);
    logic [8*STAMP_LEN-1:0] field;
    field = {seq, sec, 2'b00, nsec};
    if (idx >= STAMP_LEN) return '0;
    return field[8*(STAMP_LEN-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/traffic_generator_stream_if.sv
// Frame-buffer read port and transmit byte-lane stream of the traffic generator.
interface traffic_generator_stream_if #(
  parameter int unsigned LANES          = 1,
  parameter int unsigned BUF_ADDR_WIDTH = 9
);
  logic [BUF_ADDR_WIDTH-1:0] buf_addr;
  logic [8*LANES-1:0]        buf_data;
  logic [8*LANES-1:0]        tx_d;
  logic [LANES-1:0]          tx_en;
  logic                      tx_er;

  modport master (output buf_addr, tx_d, tx_en, tx_er, input buf_data);
  modport slave  (input buf_addr, tx_d, tx_en, tx_er, output buf_data);
endinterface

// File: rtl/tg_stamp_mux.sv
// Per-lane overwrite of buffer bytes with sequence/timestamp bytes by absolute frame index.
module tg_stamp_mux
  import traffic_generator_pkg::*;
#(
  parameter int unsigned LANES          = 1,
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned SIZE_WIDTH     = 12
) (
  input  logic [BUF_ADDR_WIDTH:0] beat,
  input  logic                    stamp_en,
  input  logic [SIZE_WIDTH-1:0]   stamp_offset,
  input  logic [31:0]             seq,
  input  logic [47:0]             sec,
  input  logic [29:0]             nsec,
  input  logic [8*LANES-1:0]      data_in,
  output logic [8*LANES-1:0]      data_out
);
  int unsigned idx;
  int unsigned rel;

  always_comb begin
    data_out = data_in;
    idx      = 0;
    rel      = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = 32'(beat) * LANES + l;
      rel = idx - 32'(stamp_offset);
      if (stamp_en && idx >= 32'(stamp_offset) && rel < STAMP_LEN)
        data_out[8*l +: 8] = stamp_byte(rel, seq, sec, nsec);
    end
  end
endmodule

// File: rtl/traffic_generator_stream.sv
// Template-frame stream generator with burst shaping and optional seq/time stamping.
module traffic_generator_stream
  import traffic_generator_pkg::*;
#(
  parameter int unsigned LANES          = 1,
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned SIZE_WIDTH     = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      run,
  input  logic [SIZE_WIDTH-1:0]     frame_size,
  input  logic [31:0]               interframe_gap,
  input  logic [31:0]               interburst_gap,
  input  logic [15:0]               frames_per_burst,
  input  logic [31:0]               total_frames,
  input  logic                      stamp_en,
  input  logic [SIZE_WIDTH-1:0]     stamp_offset,
  input  logic [47:0]               sec,
  input  logic [29:0]               nsec,
  traffic_generator_stream_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               frames_sent
);
  localparam int unsigned MAX_BYTES = (2**BUF_ADDR_WIDTH) * LANES;
  localparam int unsigned BW        = BUF_ADDR_WIDTH + 1;

  tg_state_t        state, state_next;
  logic             run_q;
  logic [BW-1:0]    nbeats, beat, nbeats_c;
  logic [LANES-1:0] last_keep, keep_c;
  logic [31:0]      seq, size_c, gap_cnt, gap_sel, gap_load;
  logic [47:0]      sec_q;
  logic [29:0]      nsec_q;
  logic [15:0]      burst_cnt, burst_next;
  logic [8*LANES-1:0] stamped;
  logic             last_beat, frames_left, can_start, burst_end;

  // Oversized frames clamp to the whole buffer, which always leaves full lanes on the last beat.
  always_comb begin
    size_c   = (32'(frame_size) > MAX_BYTES) ? MAX_BYTES : 32'(frame_size);
    nbeats_c = BW'((size_c + LANES - 1) / LANES);
    keep_c   = '0;
    for (int unsigned l = 0; l < LANES; l++)
      if ((size_c % LANES) == 0 || l < (size_c % LANES)) keep_c[l] = 1'b1;
  end

  always_comb begin
    last_beat   = (beat == nbeats - 1'b1);
    frames_left = (total_frames == '0) || (frames_sent < total_frames);
    can_start   = run_q && (frame_size != '0) && frames_left;
    burst_next  = burst_cnt + 1'b1;
    burst_end   = (frames_per_burst != '0) && (burst_next == frames_per_burst);
    gap_sel     = burst_end ? interburst_gap : interframe_gap;
    gap_load    = (gap_sel < 32'd2) ? '0 : gap_sel - 32'd2;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (can_start) state_next = LOAD;
      LOAD:    state_next = FRAME;
      FRAME:   if (last_beat) state_next = GAP;
      GAP:     if (gap_cnt == '0) state_next = can_start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  tg_stamp_mux #(
    .LANES(LANES),
    .BUF_ADDR_WIDTH(BUF_ADDR_WIDTH),
    .SIZE_WIDTH(SIZE_WIDTH)
  ) u_stamp (
    .beat(beat),
    .stamp_en(stamp_en),
    .stamp_offset(stamp_offset),
    .seq(seq),
    .sec(sec_q),
    .nsec(nsec_q),
    .data_in(bus.buf_data),
    .data_out(stamped)
  );

  // Address runs one beat ahead of the beat being sent to absorb the buffer read latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q        <= 1'b0;
      bus.buf_addr <= '0;
      bus.tx_d     <= '0;
      bus.tx_en    <= '0;
      frames_sent  <= '0;
      burst_cnt    <= '0;
      nbeats       <= '0;
      beat         <= '0;
      last_keep    <= '0;
      seq          <= '0;
      sec_q        <= '0;
      nsec_q       <= '0;
      gap_cnt      <= '0;
    end else begin
      run_q        <= run;
      bus.buf_addr <= (state_next == FRAME) ? bus.buf_addr + 1'b1 : '0;
      bus.tx_d     <= '0;
      bus.tx_en    <= '0;
      case (state)
        IDLE: if (!run_q) begin
          frames_sent <= '0;
          burst_cnt   <= '0;
        end
        LOAD: begin
          nbeats    <= nbeats_c;
          last_keep <= keep_c;
          seq       <= frames_sent;
          sec_q     <= sec;
          nsec_q    <= nsec;
          beat      <= '0;
        end
        FRAME: begin
          bus.tx_d  <= stamped;
          bus.tx_en <= last_beat ? last_keep : '1;
          beat      <= beat + 1'b1;
          if (last_beat) begin
            frames_sent <= frames_sent + 1'b1;
            burst_cnt   <= burst_end ? '0 : burst_next;
            gap_cnt     <= gap_load;
          end
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.tx_er = 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (total_frames != '0) && (frames_sent == total_frames);
endmodule

// File: tb/tb_traffic_generator_stream.sv
// Directed bench: three generator instances (1, 4 and 8 lanes) sharing one control set.
module tb_traffic_generator_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, run, stamp_en;
  logic [11:0] frame_size, stamp_offset;
  logic [31:0] ifg, ibg, total;
  logic [15:0] fpb;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic        busy1, busy4, busy8, done1, done4, done8;
  logic [31:0] fsent1, fsent4, fsent8;

  traffic_generator_stream_if #(.LANES(1), .BUF_ADDR_WIDTH(9)) bus1 ();
  traffic_generator_stream_if #(.LANES(4), .BUF_ADDR_WIDTH(9)) bus4 ();
  traffic_generator_stream_if #(.LANES(8), .BUF_ADDR_WIDTH(9)) bus8 ();

  traffic_generator_stream #(.LANES(1), .BUF_ADDR_WIDTH(9), .SIZE_WIDTH(12)) dut1 (
    .clk(clk), .resetn(resetn), .run(run), .frame_size(frame_size), .interframe_gap(ifg),
    .interburst_gap(ibg), .frames_per_burst(fpb), .total_frames(total), .stamp_en(stamp_en),
    .stamp_offset(stamp_offset), .sec(sec), .nsec(nsec), .bus(bus1), .busy(busy1),
    .done(done1), .frames_sent(fsent1));
  traffic_generator_stream #(.LANES(4), .BUF_ADDR_WIDTH(9), .SIZE_WIDTH(12)) dut4 (
    .clk(clk), .resetn(resetn), .run(run), .frame_size(frame_size), .interframe_gap(ifg),
    .interburst_gap(ibg), .frames_per_burst(fpb), .total_frames(total), .stamp_en(stamp_en),
    .stamp_offset(stamp_offset), .sec(sec), .nsec(nsec), .bus(bus4), .busy(busy4),
    .done(done4), .frames_sent(fsent4));
  traffic_generator_stream #(.LANES(8), .BUF_ADDR_WIDTH(9), .SIZE_WIDTH(12)) dut8 (
    .clk(clk), .resetn(resetn), .run(run), .frame_size(frame_size), .interframe_gap(ifg),
    .interburst_gap(ibg), .frames_per_burst(fpb), .total_frames(total), .stamp_en(stamp_en),
    .stamp_offset(stamp_offset), .sec(sec), .nsec(nsec), .bus(bus8), .busy(busy8),
    .done(done8), .frames_sent(fsent8));

  function automatic logic [7:0] mem_byte(input int k);
    return 8'((k * 13 + 5) & 255);
  endfunction

  // Frame buffers: one-cycle read latency, byte k of the template at lane k%L of word k/L.
  always @(posedge clk) begin
    bus1.buf_data <= mem_byte(int'(bus1.buf_addr));
    for (int l = 0; l < 4; l++) bus4.buf_data[8*l +: 8] <= mem_byte(int'(bus4.buf_addr) * 4 + l);
    for (int l = 0; l < 8; l++) bus8.buf_data[8*l +: 8] <= mem_byte(int'(bus8.buf_addr) * 8 + l);
  end

  int          sel;
  logic [63:0] mon_d;
  logic [7:0]  mon_en;
  always_comb begin
    mon_d  = '0;
    mon_en = '0;
    case (sel)
      1: begin mon_d[7:0]  = bus1.tx_d; mon_en[0]   = bus1.tx_en[0]; end
      4: begin mon_d[31:0] = bus4.tx_d; mon_en[3:0] = bus4.tx_en;    end
      8: begin mon_d       = bus8.tx_d; mon_en      = bus8.tx_en;    end
      default: ;
    endcase
  end

  int n_pass = 0;
  int n_total = 0;
  int first_on;
  int frame_len[$];
  int gap_len[$];
  logic [7:0] fb [0:1023];
  int fb_len, beats, bad_en;
  logic [7:0] last_en;
  logic [7:0] exp_st [0:13];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want summary");
    $fatal(1);
  end

  task automatic idle_all();
    int t;
    run = 1'b0;
    t = 0;
    while ((busy1 || busy4 || busy8) && t < 2000) begin @(negedge clk); t++; end
    n_total++;
    if (busy1 || busy4 || busy8) $display("FAIL idle_wait: got busy after %0d cycles, want idle", t);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  // Records frame and inter-frame idle lengths on the selected tx_en, one sample per negedge.
  task automatic capture(input int cycles);
    int on_run, off_run;
    bit seen;
    frame_len.delete();
    gap_len.delete();
    first_on = -1;
    on_run = 0; off_run = 0; seen = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (mon_en != 0) begin
        if (on_run == 0 && seen) gap_len.push_back(off_run);
        if (first_on < 0) first_on = i;
        on_run++; off_run = 0;
      end else begin
        if (on_run != 0) begin frame_len.push_back(on_run); seen = 1; end
        on_run = 0; off_run++;
      end
    end
  endtask

  task automatic grab_frame();
    int t;
    logic [7:0] full;
    full = (sel == 8) ? 8'hFF : (sel == 4) ? 8'h0F : 8'h01;
    fb_len = 0; beats = 0; bad_en = 0; last_en = '0; t = 0;
    while (mon_en == 0 && t < 500) begin @(negedge clk); t++; end
    n_total++;
    if (mon_en == 0) begin
      $display("FAIL frame_start: got no tx_en in %0d cycles, want a frame", t);
      return;
    end
    n_pass++;
    while (mon_en != 0 && beats < 600) begin
      if (beats > 0 && last_en != full) bad_en++;
      last_en = mon_en;
      for (int l = 0; l < 8; l++)
        if (mon_en[l]) begin fb[fb_len] = mon_d[8*l +: 8]; fb_len++; end
      beats++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; run = 1'b0; frame_size = 12'd64; total = 32'd3;
    repeat (3) @(negedge clk);
    n_total++; if (bus1.tx_en !== 1'b0)  $display("FAIL rst_tx_en1: got %0h want 0", bus1.tx_en); else n_pass++;
    n_total++; if (bus8.tx_en !== 8'h00) $display("FAIL rst_tx_en8: got %0h want 0", bus8.tx_en); else n_pass++;
    n_total++; if (bus8.tx_d !== 64'h0)  $display("FAIL rst_tx_d8: got %0h want 0", bus8.tx_d); else n_pass++;
    n_total++; if (bus1.tx_er !== 1'b0)  $display("FAIL rst_tx_er: got %0h want 0", bus1.tx_er); else n_pass++;
    n_total++; if (bus1.buf_addr !== 9'h0) $display("FAIL rst_buf_addr: got %0h want 0", bus1.buf_addr); else n_pass++;
    n_total++; if (busy1 !== 1'b0)       $display("FAIL rst_busy: got %0h want 0", busy1); else n_pass++;
    n_total++; if (done1 !== 1'b0)       $display("FAIL rst_done: got %0h want 0", done1); else n_pass++;
    n_total++; if (fsent1 !== 32'h0)     $display("FAIL rst_frames_sent: got %0h want 0", fsent1); else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gmii_frames();
    sel = 1; frame_size = 12'd64; ifg = 32'd12; ibg = 32'd0; fpb = 16'd0; total = 32'd3; stamp_en = 1'b0;
    @(negedge clk);
    run = 1'b1;
    capture(300);
    n_total++; if (first_on !== 4) $display("FAIL gmii_latency: got %0d want 4", first_on); else n_pass++;
    n_total++; if (frame_len.size() !== 3) $display("FAIL gmii_nframes: got %0d want 3", frame_len.size()); else n_pass++;
    foreach (frame_len[i]) begin
      n_total++; if (frame_len[i] !== 64) $display("FAIL gmii_len%0d: got %0d want 64", i, frame_len[i]); else n_pass++;
    end
    n_total++; if (gap_len.size() !== 2) $display("FAIL gmii_ngaps: got %0d want 2", gap_len.size()); else n_pass++;
    foreach (gap_len[i]) begin
      n_total++; if (gap_len[i] !== 12) $display("FAIL gmii_gap%0d: got %0d want 12", i, gap_len[i]); else n_pass++;
    end
    n_total++; if (done1 !== 1'b1)   $display("FAIL gmii_done: got %0h want 1", done1); else n_pass++;
    n_total++; if (fsent1 !== 32'd3) $display("FAIL gmii_frames_sent: got %0d want 3", fsent1); else n_pass++;
    n_total++; if (busy1 !== 1'b0)   $display("FAIL gmii_busy_end: got %0h want 0", busy1); else n_pass++;
    run = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (fsent1 !== 32'd0) $display("FAIL gmii_clear: got %0d want 0", fsent1); else n_pass++;
    n_total++; if (done1 !== 1'b0)   $display("FAIL gmii_done_clear: got %0h want 0", done1); else n_pass++;
    idle_all();
  endtask

  task automatic test_lanes4();
    int bad;
    sel = 4; frame_size = 12'd61; ifg = 32'd4; total = 32'd1; stamp_en = 1'b0;
    @(negedge clk);
    run = 1'b1;
    grab_frame();
    bad = 0;
    for (int k = 0; k < fb_len; k++) if (fb[k] !== mem_byte(k)) bad++;
    n_total++; if (beats !== 16)      $display("FAIL l4_beats: got %0d want 16", beats); else n_pass++;
    n_total++; if (last_en !== 8'h01) $display("FAIL l4_last_keep: got %0h want 1", last_en); else n_pass++;
    n_total++; if (bad_en !== 0)      $display("FAIL l4_full_lanes: got %0d partial beats want 0", bad_en); else n_pass++;
    n_total++; if (fb_len !== 61)     $display("FAIL l4_bytes: got %0d want 61", fb_len); else n_pass++;
    n_total++; if (bad !== 0)         $display("FAIL l4_data: got %0d wrong bytes want 0", bad); else n_pass++;
    idle_all();
  endtask

  task automatic test_burst();
    int want_gap [4];
    want_gap = '{4, 100, 4, 100};
    sel = 1; frame_size = 12'd16; fpb = 16'd2; ifg = 32'd4; ibg = 32'd100; total = 32'd5; stamp_en = 1'b0;
    @(negedge clk);
    run = 1'b1;
    capture(400);
    n_total++; if (frame_len.size() !== 5) $display("FAIL burst_nframes: got %0d want 5", frame_len.size()); else n_pass++;
    n_total++; if (gap_len.size() !== 4)   $display("FAIL burst_ngaps: got %0d want 4", gap_len.size()); else n_pass++;
    foreach (gap_len[i]) if (i < 4) begin
      n_total++;
      if (gap_len[i] !== want_gap[i]) $display("FAIL burst_gap%0d: got %0d want %0d", i, gap_len[i], want_gap[i]);
      else n_pass++;
    end
    n_total++; if (fsent1 !== 32'd5) $display("FAIL burst_frames_sent: got %0d want 5", fsent1); else n_pass++;
    n_total++; if (done1 !== 1'b1)   $display("FAIL burst_done: got %0h want 1", done1); else n_pass++;
    idle_all();
    fpb = 16'd0;
  endtask

  task automatic test_stamp();
    int bad, off;
    logic [7:0] e;
    sel = 8; frame_size = 12'd64; ifg = 32'd4; total = 32'd2; stamp_en = 1'b1; stamp_offset = 12'd42;
    sec = 48'h000102030405; nsec = 30'd7; off = 42;
    @(negedge clk);
    run = 1'b1;
    for (int n = 0; n < 2; n++) begin
      exp_st = '{8'h00, 8'h00, 8'h00, 8'(n), 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h07};
      grab_frame();
      bad = 0;
      for (int k = 0; k < fb_len; k++) begin
        e = (k >= off && k < off + 14) ? exp_st[k - off] : mem_byte(k);
        if (fb[k] !== e) bad++;
      end
      n_total++; if (fb_len !== 64) $display("FAIL stamp_len%0d: got %0d want 64", n, fb_len); else n_pass++;
      n_total++; if (bad !== 0) $display("FAIL stamp_bytes%0d: got %0d wrong bytes want 0", n, bad); else n_pass++;
      n_total++; if (fb[45] !== 8'(n)) $display("FAIL stamp_seq%0d: got %0h want %0h", n, fb[45], n); else n_pass++;
    end
    idle_all();
    // Stamp running past the end of a short frame; the tail bytes are simply never sent.
    frame_size = 12'd61; stamp_offset = 12'd58; off = 58; total = 32'd1;
    exp_st = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
               8'h00, 8'h00, 8'h00, 8'h07};
    @(negedge clk);
    run = 1'b1;
    grab_frame();
    bad = 0;
    for (int k = 0; k < fb_len; k++) begin
      e = (k >= off && k < off + 14) ? exp_st[k - off] : mem_byte(k);
      if (fb[k] !== e) bad++;
    end
    n_total++; if (last_en !== 8'h1F) $display("FAIL stamp_tail_keep: got %0h want 1f", last_en); else n_pass++;
    n_total++; if (fb_len !== 61)     $display("FAIL stamp_tail_len: got %0d want 61", fb_len); else n_pass++;
    n_total++; if (bad !== 0)         $display("FAIL stamp_tail_bytes: got %0d wrong bytes want 0", bad); else n_pass++;
    idle_all();
    stamp_en = 1'b0;
  endtask

  task automatic test_stop();
    int nfr, beat, len2;
    logic [31:0] fs_after;
    bit was_on;
    sel = 1; frame_size = 12'd20; ifg = 32'd6; total = 32'd10;
    nfr = 0; beat = 0; len2 = 0; fs_after = '1; was_on = 0;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mon_en != 0) begin
        if (!was_on) begin nfr++; beat = 0; end
        beat++;
        if (nfr == 2 && beat == 5) run = 1'b0;
        was_on = 1;
      end else begin
        if (was_on && nfr == 2) begin len2 = beat; fs_after = fsent1; end
        was_on = 0;
      end
    end
    n_total++; if (nfr !== 2)         $display("FAIL stop_nframes: got %0d want 2", nfr); else n_pass++;
    n_total++; if (len2 !== 20)       $display("FAIL stop_len2: got %0d want 20", len2); else n_pass++;
    n_total++; if (fs_after !== 32'd2) $display("FAIL stop_frames_sent: got %0d want 2", fs_after); else n_pass++;
    n_total++; if (busy1 !== 1'b0)    $display("FAIL stop_busy: got %0h want 0", busy1); else n_pass++;
    n_total++; if (fsent1 !== 32'd0)  $display("FAIL stop_clear: got %0d want 0", fsent1); else n_pass++;
    idle_all();
  endtask

  task automatic test_reset_midframe();
    int t;
    sel = 1; frame_size = 12'd64; ifg = 32'd4; total = 32'd0;
    @(negedge clk);
    run = 1'b1;
    t = 0;
    while (mon_en == 0 && t < 50) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    n_total++; if (bus1.tx_en !== 1'b1) $display("FAIL mid_active: got %0h want 1", bus1.tx_en); else n_pass++;
    resetn = 1'b0;
    @(negedge clk);
    n_total++; if (bus1.tx_en !== 1'b0)    $display("FAIL mid_rst_tx_en: got %0h want 0", bus1.tx_en); else n_pass++;
    n_total++; if (busy1 !== 1'b0)         $display("FAIL mid_rst_busy: got %0h want 0", busy1); else n_pass++;
    n_total++; if (bus1.buf_addr !== 9'h0) $display("FAIL mid_rst_buf_addr: got %0h want 0", bus1.buf_addr); else n_pass++;
    n_total++; if (bus1.tx_d !== 8'h0)     $display("FAIL mid_rst_tx_d: got %0h want 0", bus1.tx_d); else n_pass++;
    resetn = 1'b1;
    capture(10);
    n_total++; if (first_on !== 4) $display("FAIL mid_restart_latency: got %0d want 4", first_on); else n_pass++;
    idle_all();
  endtask

  initial begin
    sel = 1; run = 1'b0; resetn = 1'b0; stamp_en = 1'b0; stamp_offset = '0;
    ifg = 32'd12; ibg = 32'd0; fpb = 16'd0; total = 32'd0; frame_size = '0;
    sec = '0; nsec = '0;
    test_reset();
    test_gmii_frames();
    test_lanes4();
    test_burst();
    test_stamp();
    test_stop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
